// File: rtl/memtest_reporter_pkg.sv
// Shared encodings for the SRAM tester status reporter: LED states, status
// byte indices, ZX port numbers and a saturating counter helper.
`timescale 1ns/1ps
package memtest_reporter_pkg;

  localparam logic [2:0] LED_RUN  = 3'b001;
  localparam logic [2:0] LED_OK   = 3'b010;
  localparam logic [2:0] LED_FAIL = 3'b100;

  localparam logic [2:0] IDX_STATE   = 3'd0;
  localparam logic [2:0] IDX_PASS_LO = 3'd1;
  localparam logic [2:0] IDX_PASS_HI = 3'd2;
  localparam logic [2:0] IDX_ERR_LO  = 3'd3;
  localparam logic [2:0] IDX_ERR_HI  = 3'd4;
  localparam logic [2:0] IDX_FE_0    = 3'd5;
  localparam logic [2:0] IDX_FE_1    = 3'd6;
  localparam logic [2:0] IDX_FE_2    = 3'd7;

  localparam logic [7:0] ZX_PORT_DATA  = 8'h34;
  localparam logic [7:0] ZX_PORT_INDEX = 8'h35;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/memtest_reporter_zx_strobe_sync.sv
// Brings an async ZX IORQ+RD/WR strobe pair into the clk domain; emits either
// the synchronised level or a one-clk pulse on its assertion.
`timescale 1ns/1ps
module zx_strobe_sync #(
  parameter bit EDGE = 1'b0
)(
  input  logic clk,
  input  logic rst_n,
  input  logic iorq_n,
  input  logic rw_n,
  output logic strobe
);

  logic [1:0] iorq_sync;
  logic [1:0] rw_sync;
  logic       active;
  logic       active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iorq_sync <= '1;
      rw_sync   <= '1;
      active_q  <= 1'b0;
    end else begin
      iorq_sync <= {iorq_sync[0], iorq_n};
      rw_sync   <= {rw_sync[0], rw_n};
      active_q  <= active;
    end
  end

  assign active = ~iorq_sync[1] & ~rw_sync[1];
  assign strobe = EDGE ? (active & ~active_q) : active;

endmodule

// File: rtl/memtest_reporter.sv
// SRAM tester status reporter: pass/error counters, first failing address,
// LED blink code and an indexed ZX I/O port pair for reading it all back.
`timescale 1ns/1ps
module memtest_reporter
  import memtest_reporter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 21,
  parameter int unsigned SLOW_LOG2  = 24,
  parameter int unsigned FAST_LOG2  = 21,
  parameter logic [7:0]  PORT_DATA  = ZX_PORT_DATA,
  parameter logic [7:0]  PORT_INDEX = ZX_PORT_INDEX
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pass_stb,
  input  logic              err_stb,
  input  logic [ADDR_W-1:0] err_addr,
  input  logic [7:0]        zxa,
  input  logic [7:0]        zxid_in,
  input  logic              zxiorq_n,
  input  logic              zxrd_n,
  input  logic              zxwr_n,
  output logic [7:0]        zxid_out,
  output logic              zxid_oe,
  output logic              zxblkiorq_n,
  output logic              led
);

  localparam int unsigned BLINK_W = (SLOW_LOG2 > FAST_LOG2) ? SLOW_LOG2 : FAST_LOG2;
  localparam int unsigned FE_W    = (ADDR_W > 24) ? 24 : ADDR_W;

  logic [15:0]        pass_cnt;
  logic [15:0]        err_cnt;
  logic [ADDR_W-1:0]  first_err;
  logic [2:0]         index;
  logic [7:0]         snap;
  logic [7:0]         status_byte;
  logic [23:0]        fe_ext;
  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [BLINK_W-1:0] blink;
  logic               led_q;
  logic               rd_active;
  logic               wr_rise;
  logic               slow_wrap;
  logic               fast_wrap;
  logic               unused_zxid_hi;

  zx_strobe_sync #(.EDGE(1'b0)) u_rd_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .iorq_n (zxiorq_n),
    .rw_n   (zxrd_n),
    .strobe (rd_active)
  );

  zx_strobe_sync #(.EDGE(1'b1)) u_wr_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .iorq_n (zxiorq_n),
    .rw_n   (zxwr_n),
    .strobe (wr_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt  <= '0;
      err_cnt   <= '0;
      first_err <= '0;
    end else begin
      if (pass_stb) pass_cnt <= sat_inc16(pass_cnt);
      if (err_stb) begin
        err_cnt <= sat_inc16(err_cnt);
        if (err_cnt == '0) first_err <= err_addr;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (err_stb)
      state_nxt = LED_FAIL;
    else if (pass_stb && state == LED_RUN && err_cnt == '0)
      state_nxt = LED_OK;
  end

  assign slow_wrap = &blink[SLOW_LOG2-1:0];
  assign fast_wrap = &blink[FAST_LOG2-1:0];

  // Blink phase restarts on every state change so the first toggle lands a full half-period in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LED_RUN;
      blink <= '0;
      led_q <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        blink <= '0;
      end else begin
        blink <= blink + BLINK_W'(1);
        if ((state == LED_OK && slow_wrap) || (state == LED_FAIL && fast_wrap))
          led_q <= ~led_q;
      end
    end
  end

  assign led = led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      index <= '0;
    else if (wr_rise && zxa == PORT_INDEX)
      index <= zxid_in[2:0];
  end

  assign unused_zxid_hi = ^zxid_in[7:3];

  always_comb begin
    fe_ext = '0;
    fe_ext[FE_W-1:0] = first_err[FE_W-1:0];
    status_byte = '0;
    case (index)
      IDX_STATE:   status_byte = {5'b0, state};
      IDX_PASS_LO: status_byte = pass_cnt[7:0];
      IDX_PASS_HI: status_byte = pass_cnt[15:8];
      IDX_ERR_LO:  status_byte = err_cnt[7:0];
      IDX_ERR_HI:  status_byte = err_cnt[15:8];
      IDX_FE_0:    status_byte = fe_ext[7:0];
      IDX_FE_1:    status_byte = fe_ext[15:8];
      IDX_FE_2:    status_byte = fe_ext[23:16];
      default:     status_byte = '0;
    endcase
  end

  // Hold the byte for the whole synchronised read so a counter update cannot tear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      snap <= '0;
    else if (!rd_active)
      snap <= status_byte;
  end

  assign zxid_out    = snap;
  assign zxid_oe     = rst_n & ~zxiorq_n & ~zxrd_n & (zxa == PORT_DATA);
  assign zxblkiorq_n = ~((zxa == PORT_DATA) | (zxa == PORT_INDEX));

endmodule

// File: tb/tb_memtest_reporter.sv
// Directed bench for memtest_reporter; ZX reads are checked by a monitor
// against expected bytes queued by the stimulus.
`timescale 1ns/1ps
module tb_memtest_reporter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pass_stb = 1'b0;
  logic        err_stb = 1'b0;
  logic [20:0] err_addr = '0;
  logic [7:0]  zxa = 8'h00;
  logic [7:0]  zxid_in = 8'h00;
  logic        zxiorq_n = 1'b1;
  logic        zxrd_n = 1'b1;
  logic        zxwr_n = 1'b1;
  logic [7:0]  zxid_out;
  logic        zxid_oe;
  logic        zxblkiorq_n;
  logic        led;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  logic [7:0]  exp_q[$];

  memtest_reporter #(
    .ADDR_W     (21),
    .SLOW_LOG2  (6),
    .FAST_LOG2  (3),
    .PORT_DATA  (8'h34),
    .PORT_INDEX (8'h35)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pass_stb    (pass_stb),
    .err_stb     (err_stb),
    .err_addr    (err_addr),
    .zxa         (zxa),
    .zxid_in     (zxid_in),
    .zxiorq_n    (zxiorq_n),
    .zxrd_n      (zxrd_n),
    .zxwr_n      (zxwr_n),
    .zxid_out    (zxid_out),
    .zxid_oe     (zxid_oe),
    .zxblkiorq_n (zxblkiorq_n),
    .led         (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: once a read has been on the bus long enough to be frozen, every
  // cycle of it must show the byte queued for that read.
  initial begin
    int         oe_cnt;
    logic [7:0] cur_exp;
    logic       have_exp;
    oe_cnt = 0;
    have_exp = 1'b0;
    cur_exp = '0;
    forever begin
      @(negedge clk);
      if (zxid_oe) begin
        oe_cnt++;
        if (oe_cnt == 3) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            have_exp = 1'b0;
            $display("FAIL read_unexpected: got %0h expected no read", zxid_out);
          end else begin
            cur_exp = exp_q.pop_front();
            have_exp = 1'b1;
          end
        end
        if (oe_cnt >= 3 && have_exp) check("read_data", {24'b0, zxid_out}, {24'b0, cur_exp});
      end else begin
        oe_cnt = 0;
        have_exp = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    pass_stb = 1'b0;
    err_stb = 1'b0;
    zxiorq_n = 1'b1;
    zxrd_n = 1'b1;
    zxwr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic zx_read(input logic [7:0] exp, input int hold);
    exp_q.push_back(exp);
    @(posedge clk);
    #1 zxa = 8'h34; zxiorq_n = 1'b0; zxrd_n = 1'b0;
    repeat (hold) @(posedge clk);
    #1 zxiorq_n = 1'b1; zxrd_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic zx_write_index(input logic [7:0] idx);
    @(posedge clk);
    #1 zxa = 8'h35; zxid_in = idx; zxiorq_n = 1'b0; zxwr_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 zxiorq_n = 1'b1; zxwr_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pulse_pass(input int n);
    if (n > 0) begin
      @(posedge clk);
      #1 pass_stb = 1'b1;
      repeat (n) @(posedge clk);
      #1 pass_stb = 1'b0;
    end
  endtask

  task automatic led_wait(input string nm, input int budget, output int unsigned t);
    logic l0;
    logic seen;
    l0 = led;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (led !== l0) begin
        seen = 1'b1;
        break;
      end
    end
    t = cyc;
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: led stuck at %0b, required toggle within %0d clk", nm, l0, budget);
    end
  endtask

  initial begin
    int unsigned t0, t1, t2, te;

    do_reset();
    check("reset_led", {31'b0, led}, 32'd1);
    zx_read(8'h01, 5);

    @(posedge clk);
    #1 zxa = 8'h33; zxiorq_n = 1'b0; zxrd_n = 1'b0;
    #1 check("oe_wrong_port", {31'b0, zxid_oe}, 32'd0);
    check("blk_wrong_port", {31'b0, zxblkiorq_n}, 32'd1);
    zxa = 8'h35;
    #1 check("blk_index_port", {31'b0, zxblkiorq_n}, 32'd0);
    zxiorq_n = 1'b1; zxrd_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    pulse_pass(3);
    zx_write_index(8'd1);
    zx_read(8'h03, 5);
    zx_write_index(8'd0);
    zx_read(8'h02, 5);
    led_wait("ok_toggle0", 200, t0);
    led_wait("ok_toggle1", 200, t1);
    led_wait("ok_toggle2", 200, t2);
    check("ok_period_a", t1 - t0, 32'd64);
    check("ok_period_b", t2 - t1, 32'd64);

    @(posedge clk);
    #1 err_stb = 1'b1; err_addr = 21'h1ABCDE;
    @(posedge clk);
    #1 err_addr = 21'h000001;
    @(posedge clk);
    #1 err_stb = 1'b0;
    zx_write_index(8'd3); zx_read(8'h02, 5);
    zx_write_index(8'd4); zx_read(8'h00, 5);
    zx_write_index(8'd5); zx_read(8'hDE, 5);
    zx_write_index(8'd6); zx_read(8'hBC, 5);
    zx_write_index(8'd7); zx_read(8'h1A, 5);
    zx_write_index(8'd0); zx_read(8'h04, 5);
    led_wait("fail_toggle0", 40, t0);
    led_wait("fail_toggle1", 40, t1);
    check("fail_period", t1 - t0, 32'd8);

    zx_write_index(8'd1);
    fork
      zx_read(8'h03, 20);
      begin
        repeat (4) @(posedge clk);
        pulse_pass(5);
      end
    join
    zx_read(8'h08, 5);

    @(posedge clk);
    #1 zxa = 8'h34; zxiorq_n = 1'b0; zxrd_n = 1'b0;
    @(negedge clk);
    #1 check("oe_during_read", {31'b0, zxid_oe}, 32'd1);
    rst_n = 1'b0;
    #1 check("oe_reset_mid_read", {31'b0, zxid_oe}, 32'd0);
    check("snap_reset_mid_read", {24'b0, zxid_out}, 32'd0);
    zxiorq_n = 1'b1; zxrd_n = 1'b1;
    do_reset();

    @(posedge clk);
    #1 pass_stb = 1'b1; err_stb = 1'b1; err_addr = 21'h0A5A5A;
    @(posedge clk);
    #1 pass_stb = 1'b0; err_stb = 1'b0;
    te = cyc;
    led_wait("fail_first_toggle", 40, t0);
    check("fail_first_delay", t0 - te, 32'd8);
    zx_read(8'h04, 5);
    zx_write_index(8'd1); zx_read(8'h01, 5);
    zx_write_index(8'd3); zx_read(8'h01, 5);
    zx_write_index(8'd5); zx_read(8'h5A, 5);
    zx_write_index(8'd7); zx_read(8'h0A, 5);

    do_reset();
    pulse_pass(65534);
    zx_write_index(8'd1); zx_read(8'hFE, 5);
    zx_write_index(8'd2); zx_read(8'hFF, 5);
    pulse_pass(3);
    zx_read(8'hFF, 5);
    zx_write_index(8'd1); zx_read(8'hFF, 5);

    repeat (5) @(posedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL reads_pending: got %0d unread expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
